switch_port_voq: RTL
====================

Name: switch_port_voq

Overview:
Next-generation ingress port for the N-port switch. It replaces the single shared FIFO with one virtual output queue (VOQ) per destination, which removes head-of-line blocking. Each queue issues its own request to that destination's output arbiter. A mode selects either backpressure or drop-on-full, and saturating per-queue drop counters are provided for status.

Parameters:
WIDTH, 8, data word width in bits
DEPTH, 8, entries per VOQ (power of 2, >=2)
N_PORTS, 4, number of destinations/VOQs (>=2)
CNT_W, 8, width of each saturating drop counter

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
mode_i  in  1  0=BLOCK (backpressure), 1=DROP (never stall); sampled every cycle
flush_i  in  1  synchronous clear of all VOQs (drop counters kept)
valid_in  in  1  ingress word valid
ready_out  out  1  ingress ready; transfer when valid_in&&ready_out
data_in  in  WIDTH  ingress data
target_in  in  $clog2(N_PORTS)  destination index of the ingress word
req_o  out  N_PORTS  bit d = VOQ d non-empty
grant_i  in  N_PORTS  bit d = output arbiter d accepts head of VOQ d this cycle
data_o  out  N_PORTS x WIDTH  packed; slice d = head word of VOQ d
level_o  out  N_PORTS x $clog2(DEPTH+1)  packed; occupancy per VOQ
drop_cnt_o  out  N_PORTS x CNT_W  packed; saturating drop count per VOQ

Behaviour:
- Reset (async, rst_n low): all pointers, levels, and drop counters go to 0. req_o=0, data_o=0, level_o=0, drop_cnt_o=0. ready_out=1 in both modes.
- Pop: VOQ d pops when req_o[d]&&grant_i[d]. A grant on an empty queue is ignored, with no pointer or level change.
- Push: accepted word goes to VOQ[target_in]. It is visible on req_o/data_o/level_o the next cycle (1-cycle latency). No same-cycle bypass.
- A simultaneous push and pop on the same VOQ leaves level unchanged, and both pointers advance.
- BLOCK mode: ready_out = !full[target_in] || (req_o[target_in]&&grant_i[target_in]). This is a combinational path from target_in/grant_i to ready_out, and it is permitted. Other queues' fullness never affects ready_out.
- DROP mode: ready_out=1 always. If valid_in and VOQ[target_in] is full with no pop that cycle, the word is discarded and drop_cnt[target_in] increments, saturating at 2^CNT_W-1.
- A mode_i change takes effect the same cycle. Queued contents are unaffected.
- flush_i: next cycle all levels=0 and req_o=0. Pops and pushes in the flush cycle are discarded and not counted as drops. ready_out remains per mode.
- target_in >= N_PORTS: the word is accepted and discarded, and nothing is counted. Assertion in sim.
- data_o slice d = 0 when VOQ d is empty; otherwise mem[rd_ptr]. The read is combinational from registered storage.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Level is $clog2(DEPTH+1) bits. full = (level==DEPTH).
- Burst: with grant held, VOQ d drains one word per cycle with no bubble.

Decomposition:
- Package switch_pkg:
  - mode enum (MODE_BLOCK=0, MODE_DROP=1)
  - DEST_W = $clog2(N_PORTS) helper
  - default WIDTH/DEPTH constants, shared with the arbiter and output mux
- One sub-module, voq_fifo:
  - single-queue FIFO: push, pop, flush, level, full/empty, head data zeroed when empty
  - instantiated N_PORTS times via generate
- The top level holds push steering, the ready/mode logic, and the drop counters.

Test Plan:
- Basic/latency: reset, BLOCK; push 0xA1 to dest 2 -> next cycle req_o=4'b0100, data_o[2]=0xA1, level_o[2]=1; grant_i=4'b0100 one cycle -> req_o=0, data_o[2]=0.
- No HOL blocking: fill VOQ1 with 8 words, no grants, ready_out=0 for target 1 -> push 0x55 to dest 3 accepted (ready_out=1), req_o[3]=1 next cycle.
- Full with concurrent pop, BLOCK: VOQ0 full, grant_i[0]=1, push 0x77 to dest 0 -> ready_out=1, level_o[0] stays 8, 0x77 emerges after the 7 older words.
- DROP saturation: CNT_W=2, mode DROP, VOQ3 full, no grants; 5 pushes to dest 3 -> ready_out=1 throughout, drop_cnt_o[3]=3, level_o[3]=8, contents unchanged.
- Flush and reset mid-burst: 3 queues partly filled, grant burst on VOQ0, assert flush_i -> all req_o=0 next cycle, drop counters retained. Then assert rst_n=0 asynchronously mid-cycle -> all outputs 0 immediately.
- Wrap-around: 20 push/pop pairs through VOQ2 with data 0..19 -> output order 0..19, no loss, level never exceeds DEPTH.

Source files
------------

// File: rtl/switch_pkg.sv
// Shared types and defaults for the VOQ ingress port, its output arbiters and output mux.
package switch_pkg;

  typedef enum logic {
    MODE_BLOCK = 1'b0,
    MODE_DROP  = 1'b1
  } mode_e;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_DEPTH   = 8;
  localparam int DEF_N_PORTS = 4;

  // Destination index width; never narrower than one bit.
  function automatic int dest_w(input int n_ports);
    return (n_ports > 1) ? $clog2(n_ports) : 1;
  endfunction

endpackage

// File: rtl/voq_fifo.sv
// Single virtual output queue: power-of-2 ring buffer with flush, occupancy and
// a head word that reads as zero while the queue is empty.
module voq_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int PW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [LW-1:0]    level_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             push_en, pop_en;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LW'(DEPTH));
  assign level_o = level_q;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // A push into a full queue only lands when the head leaves in the same cycle.
  assign pop_en  = pop_i && !empty_o && !flush_i;
  assign push_en = push_i && !flush_i && (!full_o || pop_en);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_en) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_en)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push_en, pop_en})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/switch_port_voq.sv
// Ingress port with one VOQ per destination: push steering, BLOCK/DROP ready
// policy and saturating per-queue drop counters.
module switch_port_voq
  import switch_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int N_PORTS = DEF_N_PORTS,
  parameter int CNT_W   = 8,
  localparam int DW = dest_w(N_PORTS),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mode_i,
  input  logic                     flush_i,
  input  logic                     valid_in,
  output logic                     ready_out,
  input  logic [WIDTH-1:0]         data_in,
  input  logic [DW-1:0]            target_in,
  output logic [N_PORTS-1:0]       req_o,
  input  logic [N_PORTS-1:0]       grant_i,
  output logic [N_PORTS*WIDTH-1:0] data_o,
  output logic [N_PORTS*LW-1:0]    level_o,
  output logic [N_PORTS*CNT_W-1:0] drop_cnt_o
);

  logic [N_PORTS-1:0]            full, empty, pop, push;
  logic [N_PORTS-1:0][CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  mode_e                         mode;
  logic                          tgt_ok, tgt_full, tgt_pop, fire;

  assign mode       = mode_e'(mode_i);
  assign req_o      = ~empty;
  assign pop        = grant_i & req_o;
  assign drop_cnt_o = drop_cnt_q;
  assign tgt_ok     = ({1'b0, target_in} < (DW + 1)'(N_PORTS));

  // Only the addressed queue's state may influence ready_out (no HOL blocking).
  always_comb begin
    tgt_full = 1'b0;
    tgt_pop  = 1'b0;
    for (int d = 0; d < N_PORTS; d++) begin
      if (tgt_ok && target_in == DW'(d)) begin
        tgt_full = full[d];
        tgt_pop  = pop[d];
      end
    end
    ready_out = (mode == MODE_DROP) ? 1'b1 : (!tgt_full || tgt_pop);
    fire      = valid_in && ready_out;
  end

  always_comb begin
    push       = '0;
    drop_cnt_d = drop_cnt_q;
    for (int d = 0; d < N_PORTS; d++) begin
      push[d] = fire && tgt_ok && (target_in == DW'(d));
      if (push[d] && full[d] && !pop[d] && !flush_i &&
          drop_cnt_q[d] != {CNT_W{1'b1}}) begin
        drop_cnt_d[d] = drop_cnt_q[d] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  for (genvar d = 0; d < N_PORTS; d++) begin : g_voq
    voq_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_voq (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (flush_i),
      .push_i  (push[d]),
      .pop_i   (pop[d]),
      .wdata_i (data_in),
      .rdata_o (data_o[d*WIDTH +: WIDTH]),
      .level_o (level_o[d*LW +: LW]),
      .full_o  (full[d]),
      .empty_o (empty[d])
    );
  end

  a_target_in_range : assert property (@(posedge clk) disable iff (!rst_n)
    valid_in |-> tgt_ok);

endmodule
